// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out receiver with a double-buffered valid/ready output.
// A word starts with SP=1 and SYNC=1. The receiver then samples WIDTH bits on
// SP-qualified clocks and hands the finished word to a one-entry output
// register.
// Ports:
//   CK        clock, rising edge
//   LSR       synchronous active-high reset
//   SP        sample enable; SDI and SYNC are ignored while low
//   SDI       serial data bit
//   SYNC      first-bit marker, qualified by SP
//   Q         assembled word (output register)
//   Q_VALID   Q holds an unconsumed word
//   Q_READY   consumer accepts Q when Q_VALID=1
//   OVF       sticky: completed word dropped because Q was full
//   SYNC_ERR  sticky: SYNC seen while a word was partially received
//   BUSY      receiver is mid-word (SHIFT state)
module sipo_deserializer #(
   parameter int unsigned WIDTH     = 8,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic             CK,
   input  logic             LSR,
   input  logic             SP,
   input  logic             SDI,
   input  logic             SYNC,
   output logic [WIDTH-1:0] Q,
   output logic             Q_VALID,
   input  logic             Q_READY,
   output logic             OVF,
   output logic             SYNC_ERR,
   output logic             BUSY
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic             q_valid_q, q_valid_d;
   logic             ovf_q, ovf_d;
   logic             sync_err_q, sync_err_d;
   logic [WIDTH-1:0] sr_ins;
   logic             word_done;

   // Shift register contents after inserting the current SDI bit
   assign sr_ins = MSB_FIRST ? {sr_q[WIDTH-2:0], SDI} : {SDI, sr_q[WIDTH-1:1]};

   // Next-state logic: bit framing, then the output register handshake
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sr_d       = sr_q;
      q_d        = q_q;
      q_valid_d  = q_valid_q;
      ovf_d      = ovf_q;
      sync_err_d = sync_err_q;
      word_done  = 1'b0;

      if (q_valid_q && Q_READY) begin
         q_valid_d = 1'b0;
      end

      if (SP) begin
         case (state_q)
            IDLE: begin
               if (SYNC) begin
                  sr_d    = sr_ins;
                  cnt_d   = CW'(1);
                  state_d = SHIFT;
               end
            end
            SHIFT: begin
               sr_d = sr_ins;
               if (SYNC) begin
                  // Early SYNC: discard the partial word, restart at bit 1
                  sync_err_d = 1'b1;
                  cnt_d      = CW'(1);
               end else if (cnt_q == CW'(WIDTH - 1)) begin
                  cnt_d     = '0;
                  state_d   = IDLE;
                  word_done = 1'b1;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end

      // Load when the register is empty or is being drained on this edge
      if (word_done) begin
         if (!q_valid_q || Q_READY) begin
            q_d       = sr_ins;
            q_valid_d = 1'b1;
         end else begin
            ovf_d = 1'b1;
         end
      end
   end

   // State and output registers
   always_ff @(posedge CK) begin
      if (LSR) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         sr_q       <= '0;
         q_q        <= '0;
         q_valid_q  <= 1'b0;
         ovf_q      <= 1'b0;
         sync_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sr_q       <= sr_d;
         q_q        <= q_d;
         q_valid_q  <= q_valid_d;
         ovf_q      <= ovf_d;
         sync_err_q <= sync_err_d;
      end
   end

   assign Q        = q_q;
   assign Q_VALID  = q_valid_q;
   assign OVF      = ovf_q;
   assign SYNC_ERR = sync_err_q;
   assign BUSY     = (state_q == SHIFT);

endmodule
